// File: rtl/vx_barrier_unit_pkg.sv
// Shared types for the warp barrier unit: request/release records and slot state.
package vx_barrier_unit_pkg;

  localparam int DEF_NUM_WARPS    = 4;
  localparam int DEF_NUM_BARRIERS = 4;
  localparam int DEF_NW_BITS      = (DEF_NUM_WARPS > 1) ? $clog2(DEF_NUM_WARPS) : 1;
  localparam int DEF_NB_BITS      = (DEF_NUM_BARRIERS > 1) ? $clog2(DEF_NUM_BARRIERS) : 1;

  typedef struct packed {
    logic                   valid;
    logic [DEF_NB_BITS-1:0] id;
    logic [DEF_NW_BITS-1:0] size_m1;
  } gpu_barrier_t;

  localparam int GPU_BARRIER_BITS = $bits(gpu_barrier_t);

  typedef struct packed {
    logic                     valid;
    logic [DEF_NB_BITS-1:0]   id;
    logic [DEF_NUM_WARPS-1:0] mask;
  } gpu_barrier_release_t;

  localparam int GPU_BARRIER_RELEASE_BITS = $bits(gpu_barrier_release_t);

  typedef enum logic {
    SLOT_IDLE = 1'b0,
    SLOT_WAIT = 1'b1
  } slot_state_e;

endpackage

// File: rtl/vx_barrier_unit_slot.sv
// One barrier slot: tracks waiting warps, arrival count and the latched group size.
module vx_barrier_unit_slot
  import vx_barrier_unit_pkg::*;
#(
  parameter int NUM_WARPS = DEF_NUM_WARPS,
  parameter int NW_BITS   = DEF_NW_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 req,
  input  logic [NW_BITS-1:0]   size_m1,
  input  logic [NW_BITS-1:0]   wid,
  output logic                 busy,
  output logic [NUM_WARPS-1:0] mask,
  output logic                 fire,
  output logic [NUM_WARPS-1:0] fire_mask,
  output logic                 size_err
);

  slot_state_e          state_q, state_d;
  logic [NUM_WARPS-1:0] mask_q, mask_d;
  logic [NW_BITS-1:0]   count_q, count_d;
  logic [NW_BITS-1:0]   size_q, size_d;
  logic [NUM_WARPS-1:0] wid_bit;

  assign wid_bit = NUM_WARPS'(1) << wid;

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    count_d   = count_q;
    size_d    = size_q;
    fire      = 1'b0;
    fire_mask = '0;
    size_err  = 1'b0;
    if (req) begin
      case (state_q)
        SLOT_IDLE: begin
          if (size_m1 == '0) begin
            fire      = 1'b1;
            fire_mask = wid_bit;
          end else begin
            state_d = SLOT_WAIT;
            mask_d  = wid_bit;
            count_d = NW_BITS'(1);
            size_d  = size_m1;
          end
        end
        default: begin
          // A size disagreement is flagged but the group size latched by the first arrival wins.
          size_err = (size_m1 != size_q);
          if (count_q == size_q) begin
            fire      = 1'b1;
            fire_mask = mask_q | wid_bit;
            state_d   = SLOT_IDLE;
            mask_d    = '0;
            count_d   = '0;
          end else begin
            mask_d  = mask_q | wid_bit;
            count_d = count_q + NW_BITS'(1);
          end
        end
      endcase
    end
    if (flush) begin
      state_d = SLOT_IDLE;
      mask_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= SLOT_IDLE;
      mask_q  <= '0;
      count_q <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      size_q  <= size_d;
    end
  end

  assign busy = (state_q == SLOT_WAIT);
  assign mask = mask_q;

endmodule

// File: rtl/vx_barrier_unit.sv
// Warp barrier unit: routes arrivals to per-slot trackers, registers release events and errors.
module vx_barrier_unit
  import vx_barrier_unit_pkg::*;
#(
  parameter int NUM_WARPS    = DEF_NUM_WARPS,
  parameter int NUM_BARRIERS = DEF_NUM_BARRIERS,
  parameter int NB_BITS      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
  parameter int NW_BITS      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  gpu_barrier_t            barrier_in,
  input  logic [NW_BITS-1:0]      barrier_wid,
  output logic                    barrier_ready,
  input  logic                    flush,
  output logic [NUM_WARPS-1:0]    stall_mask,
  output logic                    release_valid,
  output logic [NB_BITS-1:0]      release_id,
  output logic [NUM_WARPS-1:0]    release_mask,
  output logic [NUM_BARRIERS-1:0] busy,
  output logic                    err_dup,
  output logic                    err_size
);

  logic                    accept;
  logic                    is_dup;
  logic [NUM_BARRIERS-1:0] slot_req;
  logic [NUM_BARRIERS-1:0] slot_fire;
  logic [NUM_BARRIERS-1:0] slot_size_err;
  logic [NUM_WARPS-1:0]    slot_mask      [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]    slot_fire_mask [NUM_BARRIERS];

  logic                 release_valid_q, release_valid_d;
  logic [NB_BITS-1:0]   release_id_q, release_id_d;
  logic [NUM_WARPS-1:0] release_mask_q, release_mask_d;
  logic                 err_dup_q, err_dup_d;
  logic                 err_size_q, err_size_d;

  assign barrier_ready = reset && !flush;
  assign accept        = barrier_in.valid && barrier_ready;
  // A warp already parked on any barrier cannot arrive again until released.
  assign is_dup        = stall_mask[barrier_wid];

  generate
    for (genvar gi = 0; gi < NUM_BARRIERS; gi++) begin : g_slot
      assign slot_req[gi] = accept && !is_dup && (barrier_in.id == NB_BITS'(gi));

      vx_barrier_unit_slot #(
        .NUM_WARPS (NUM_WARPS),
        .NW_BITS   (NW_BITS)
      ) u_slot (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .req       (slot_req[gi]),
        .size_m1   (barrier_in.size_m1),
        .wid       (barrier_wid),
        .busy      (busy[gi]),
        .mask      (slot_mask[gi]),
        .fire      (slot_fire[gi]),
        .fire_mask (slot_fire_mask[gi]),
        .size_err  (slot_size_err[gi])
      );
    end
  endgenerate

  always_comb begin
    stall_mask     = '0;
    release_mask_d = '0;
    for (int i = 0; i < NUM_BARRIERS; i++) begin
      stall_mask     = stall_mask | slot_mask[i];
      release_mask_d = release_mask_d | slot_fire_mask[i];
    end
    release_valid_d = |slot_fire;
    release_id_d    = release_valid_d ? barrier_in.id : '0;
    err_dup_d       = err_dup_q | (accept && is_dup);
    err_size_d      = err_size_q | (|slot_size_err);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      release_valid_q <= 1'b0;
      release_id_q    <= '0;
      release_mask_q  <= '0;
      err_dup_q       <= 1'b0;
      err_size_q      <= 1'b0;
    end else begin
      release_valid_q <= release_valid_d;
      release_id_q    <= release_id_d;
      release_mask_q  <= release_mask_d;
      err_dup_q       <= err_dup_d;
      err_size_q      <= err_size_d;
    end
  end

  assign release_valid = release_valid_q;
  assign release_id    = release_id_q;
  assign release_mask  = release_mask_q;
  assign err_dup       = err_dup_q;
  assign err_size      = err_size_q;

endmodule

// File: tb/tb_vx_barrier_unit.sv
// Scoreboard bench for vx_barrier_unit: set-based reference model, decoupled release monitor.
module tb_vx_barrier_unit;
  import vx_barrier_unit_pkg::*;

  logic         clk;
  logic         reset;
  gpu_barrier_t barrier_in;
  logic [1:0]   barrier_wid;
  logic         barrier_ready;
  logic         flush;
  logic [3:0]   stall_mask;
  logic         release_valid;
  logic [1:0]   release_id;
  logic [3:0]   release_mask;
  logic [3:0]   busy;
  logic         err_dup;
  logic         err_size;

  vx_barrier_unit dut (
    .clk           (clk),
    .reset         (reset),
    .barrier_in    (barrier_in),
    .barrier_wid   (barrier_wid),
    .barrier_ready (barrier_ready),
    .flush         (flush),
    .stall_mask    (stall_mask),
    .release_valid (release_valid),
    .release_id    (release_id),
    .release_mask  (release_mask),
    .busy          (busy),
    .err_dup       (err_dup),
    .err_size      (err_size)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    int mask;
  } rel_t;

  rel_t rel_q[$];
  int   m_set[4] = '{0, 0, 0, 0};
  int   m_req[4] = '{0, 0, 0, 0};
  bit   m_dup    = 1'b0;
  bit   m_size   = 1'b0;
  int   n_tests  = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each barrier is a set of waiting warps plus the group size set by its first arrival.
  function automatic void model_step(input bit v, input int id, input int sz, input int wid,
                                     input bit fl, input bit rst_n);
    int stalled;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin m_set[i] = 0; m_req[i] = 0; end
      m_dup  = 1'b0;
      m_size = 1'b0;
      return;
    end
    if (fl) begin
      for (int i = 0; i < 4; i++) m_set[i] = 0;
      return;
    end
    if (!v) return;
    stalled = 0;
    for (int i = 0; i < 4; i++) stalled |= m_set[i];
    if (stalled[wid]) begin
      m_dup = 1'b1;
      return;
    end
    if (m_set[id] == 0) m_req[id] = sz + 1;
    else if (sz + 1 != m_req[id]) m_size = 1'b1;
    m_set[id] |= (1 << wid);
    if ($countones(m_set[id]) == m_req[id]) begin
      rel_q.push_back('{id: id, mask: m_set[id]});
      m_set[id] = 0;
    end
  endfunction

  task automatic step(input bit v, input int id, input int sz, input int wid,
                      input bit fl, input bit rst_n);
    @(negedge clk);
    #2;
    barrier_in.valid   = v;
    barrier_in.id      = 2'(id);
    barrier_in.size_m1 = 2'(sz);
    barrier_wid        = 2'(wid);
    flush              = fl;
    reset              = rst_n;
    @(posedge clk);
    model_step(v, id, sz, wid, fl, rst_n);
  endtask

  task automatic arrive(input int id, input int sz, input int wid);
    step(1'b1, id, sz, wid, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      int exp_stall;
      int exp_busy;
      rel_t e;
      exp_stall = 0;
      exp_busy  = 0;
      for (int i = 0; i < 4; i++) begin
        exp_stall |= m_set[i];
        if (m_set[i] != 0) exp_busy |= (1 << i);
      end
      check("stall_mask", int'(stall_mask), exp_stall);
      check("busy", int'(busy), exp_busy);
      check("err_dup", int'(err_dup), int'(m_dup));
      check("err_size", int'(err_size), int'(m_size));
      check("barrier_ready", int'(barrier_ready), int'(reset && !flush));
      if (release_valid) begin
        if (rel_q.size() == 0) begin
          check("release_unexpected", 1, 0);
        end else begin
          e = rel_q.pop_front();
          $display("[TB] release id=%0d mask=%b", release_id, release_mask);
          check("release_id", int'(release_id), e.id);
          check("release_mask", int'(release_mask), e.mask);
        end
      end else begin
        check("release_missing", rel_q.size(), 0);
        rel_q.delete();
        check("release_id_idle", int'(release_id), 0);
        check("release_mask_idle", int'(release_mask), 0);
      end
    end
  end

  initial begin
    int id, sz, wid;
    bit v, fl, rst_n;
    barrier_in  = '0;
    barrier_wid = '0;
    flush       = 1'b0;
    reset       = 1'b0;
    mon_en      = 1'b1;
    step(1'b0, 0, 0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 0, 0, 1'b0, 1'b0);
    idle(1);

    // Four warps gather on barrier 1.
    for (int w = 0; w < 4; w++) arrive(1, 3, w);
    idle(2);
    // Single-warp barrier releases immediately.
    arrive(0, 0, 2);
    idle(2);
    // Duplicate arrival is ignored and flagged.
    arrive(2, 1, 1);
    arrive(2, 1, 1);
    arrive(2, 1, 3);
    idle(2);
    // Size disagreement is flagged; latched size governs.
    arrive(3, 2, 0);
    arrive(3, 1, 1);
    arrive(3, 1, 2);
    idle(2);
    // Back-to-back epochs on the same slot.
    arrive(1, 1, 0);
    arrive(1, 1, 1);
    arrive(1, 1, 2);
    arrive(1, 1, 3);
    idle(2);
    // Flush drops waiters and the simultaneous request; reset then clears errors.
    arrive(0, 3, 0);
    arrive(0, 3, 1);
    step(1'b1, 0, 3, 2, 1'b1, 1'b1);
    idle(2);
    arrive(2, 3, 0);
    step(1'b0, 0, 0, 0, 1'b0, 1'b0);
    idle(2);

    for (int n = 0; n < 600; n++) begin
      v     = ($urandom_range(0, 9) < 7);
      id    = $urandom_range(0, 3);
      sz    = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : ((id + 1) % 4);
      wid   = $urandom_range(0, 3);
      fl    = ($urandom_range(0, 39) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
      step(v, id, sz, wid, fl, rst_n);
    end
    idle(3);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("release_queue_drained", rel_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_barrier_unit.md
VX_BARRIER_UNIT -- requirements
Module: VX_barrier_unit

Interface
REQ-001 SHALL have parameter NUM_WARPS, default `NUM_WARPS (4 in bench), number of warps tracked.
REQ-002 SHALL have parameter NUM_BARRIERS, default `NUM_BARRIERS (4 in bench), number of barrier slots; NB_BITS, NW_BITS derived via `CLOG2 and `UP.
REQ-003 SHALL have one clock and a synchronous, active-low reset; ports: clk  in  1  clock; reset  in  1  synchronous active-low reset.
REQ-004 SHALL have port: barrier_in  in  GPU_BARRIER_BITS  gpu_barrier_t request; .valid is request valid, .id is barrier slot, .size_m1 is participating warps minus 1.
REQ-005 SHALL have port: barrier_wid  in  NW_BITS  id of the requesting warp.
REQ-006 SHALL have port: barrier_ready  out  1  request accepted on a clock edge when barrier_in.valid && barrier_ready.
REQ-007 SHALL have port: flush  in  1  clear all barrier state.
REQ-008 SHALL have port: stall_mask  out  NUM_WARPS  warps blocked on any barrier.
REQ-009 SHALL have ports: release_valid  out  1; release_id  out  NB_BITS; release_mask  out  NUM_WARPS; one-cycle release event.
REQ-010 SHALL have ports: busy  out  NUM_BARRIERS  slot has waiters; err_dup  out  1  sticky; err_size  out  1  sticky.

Function
REQ-011 SHALL assert barrier_ready = reset && !flush; no other backpressure.
REQ-012 Each slot SHALL be a two-state FSM: IDLE (mask 0, count 0) and WAIT (mask, count, latched size_m1).
REQ-013 Accepted request to IDLE slot with size_m1 != 0: -> WAIT, mask = bit wid, count = 1, latch size_m1.
REQ-014 Accepted request to WAIT slot with count != latched size_m1: set mask bit wid, count += 1, stay WAIT.
REQ-015 Release condition: accepted request where count == size_m1 (IDLE slot: incoming size_m1 == 0, count 0); slot -> IDLE, mask and count cleared at next edge.
REQ-016 Release SHALL be registered: last arrival accepted at edge N -> release_valid = 1 for exactly cycle N+1, release_id = slot, release_mask = prior mask | bit wid.
REQ-017 release_valid SHALL be 0 in all other cycles; release_id/release_mask SHALL be 0 when release_valid = 0.
REQ-018 stall_mask SHALL equal OR of all slot masks (registered state); arriving warp appears in stall_mask from cycle N+1 unless released at N.
REQ-019 Request from a warp whose stall_mask bit is set SHALL be ignored (no state change) and SHALL set err_dup.
REQ-020 Request to WAIT slot with size_m1 != latched value SHALL set err_size and proceed using the latched value.
REQ-021 count SHALL be NW_BITS wide; with NUM_WARPS arrivals max it never wraps.
REQ-022 A slot releasing at edge N SHALL accept a new first arrival at edge N+1 as a fresh epoch.
REQ-023 flush high at edge N: all slots IDLE, stall_mask 0, release_valid 0 at N+1; simultaneous request dropped; error flags retained.
REQ-024 busy[i] SHALL be 1 exactly when slot i is in WAIT.

Reset
REQ-025 reset low at an edge SHALL force all slots IDLE, stall_mask 0, busy 0, release_valid/id/mask 0, err_dup 0, err_size 0, barrier_ready 0.
REQ-026 Reset mid-wait SHALL discard waiters without a release event.

Structure
REQ-027 gpu_barrier_t SHALL be reused from VX_gpu_types; a new gpu_barrier_release_t {valid, id, mask} and `GPU_BARRIER_RELEASE_BITS SHALL be added to that package.
REQ-028 One sub-module VX_barrier_slot (per-slot FSM, mask, count, latched size) SHALL be instantiated NUM_BARRIERS times; release mux and error flags live in the top.

Verification
REQ-029 Warps 0,1,2,3 arrive on id 1, size_m1=3, one per cycle -> stall_mask 0001,0011,0111 then release_valid=1, id=1, mask=1111, stall_mask 0000.
REQ-030 Warp 2 arrives id 0 size_m1=0 -> next cycle release mask=0100, stall_mask never shows warp 2, busy stays 0.
REQ-031 Warp 1 arrives id 2 size_m1=1, warp 1 again -> err_dup=1, count unchanged; warp 3 arrives -> release mask=1010.
REQ-032 Warp 0 on id 3 size_m1=2, warp 1 on id 3 size_m1=1 -> err_size=1, no release; warp 2 arrives -> release mask=0111.
REQ-033 Warps 0,1 waiting on id 0, flush with simultaneous request from warp 2 -> stall_mask 0000, busy 0000, no release; reset then clears err flags.
